// File: rtl/keypad_scan_encoder.sv
`timescale 1ns/1ps
// 4x4 active-low matrix keypad scanner with full-scan debounce.
// Emits PRESS/ENTER/CLEAR pulses and a held-key level for the password lock.
module keypad_scan_encoder #(
   parameter int SCAN_DIV       = 16,
   parameter int DEBOUNCE_SCANS = 3
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [3:0] ROW,
   output logic [3:0] COL,
   output logic [3:0] CODE,
   output logic       PRESS,
   output logic       ENTER,
   output logic       CLEAR,
   output logic       KEY_DOWN
);

   localparam int SLOT_W = $clog2(SCAN_DIV);
   localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD} state_t;
   typedef enum logic [1:0] {K_DIGIT, K_ENTER, K_CLEAR, K_IGNORE} key_kind_t;

   typedef struct packed {
      key_kind_t  kind;
      logic [3:0] bcd;
   } key_info_t;

   // Key index is row*4 + col.
   function automatic key_info_t decode_key(input logic [3:0] idx);
      key_info_t info;
      info = '{kind: K_IGNORE, bcd: 4'd0};
      case (idx)
         4'd0:  info = '{K_DIGIT, 4'd1};
         4'd1:  info = '{K_DIGIT, 4'd2};
         4'd2:  info = '{K_DIGIT, 4'd3};
         4'd4:  info = '{K_DIGIT, 4'd4};
         4'd5:  info = '{K_DIGIT, 4'd5};
         4'd6:  info = '{K_DIGIT, 4'd6};
         4'd8:  info = '{K_DIGIT, 4'd7};
         4'd9:  info = '{K_DIGIT, 4'd8};
         4'd10: info = '{K_DIGIT, 4'd9};
         4'd12: info = '{K_CLEAR, 4'd0};
         4'd13: info = '{K_DIGIT, 4'd0};
         4'd14: info = '{K_ENTER, 4'd0};
         default: info = '{K_IGNORE, 4'd0};
      endcase
      return info;
   endfunction

   logic [3:0]        row_meta, row_sync, row_down;
   logic [SLOT_W-1:0] slot;
   logic [1:0]        col_idx;
   logic [15:0]       keys_acc;
   logic [15:0]       scan_keys;
   logic [4:0]        n_down;
   logic [3:0]        key_idx;
   logic              scan_end, scan_none, scan_single;
   logic              accept;
   key_info_t         accept_info;
   state_t            state;
   logic [3:0]        cand;
   logic [CNT_W-1:0]  cnt;

   assign row_down = ~row_sync;
   assign scan_end = (slot == SLOT_LAST) && (col_idx == 2'd3);

   // NOTE: all sequential state uses non-blocking assignments so every flop
   // samples pre-edge values, independent of block evaluation order.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         row_meta <= 4'b1111;
         row_sync <= 4'b1111;
      end else begin
         row_meta <= ROW;
         row_sync <= row_meta;
      end
   end

   // Column 3 samples are consumed directly at scan end, so only columns 0..2
   // are stored; the column-3 bit positions stay zero.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         slot     <= '0;
         col_idx  <= 2'd0;
         COL      <= 4'b1110;
         keys_acc <= '0;
      end else begin
         if (slot == SLOT_LAST) begin
            slot    <= '0;
            col_idx <= col_idx + 2'd1;
            COL     <= {COL[2:0], COL[3]};
            if (col_idx != 2'd3) begin
               for (int r = 0; r < 4; r++) begin
                  keys_acc[4*r + int'(col_idx)] <= row_down[r];
               end
            end
         end else begin
            slot <= slot + SLOT_W'(1);
         end
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      scan_keys = keys_acc;
      for (int r = 0; r < 4; r++) begin
         scan_keys[4*r + 3] = row_down[r];
      end
      n_down  = 5'd0;
      key_idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (scan_keys[i]) begin
            n_down  = n_down + 5'd1;
            key_idx = 4'(i);
         end
      end
      scan_none   = (n_down == 5'd0);
      scan_single = (n_down == 5'd1);
   end

   always_comb begin
      accept = 1'b0;
      if (scan_end && scan_single) begin
         case (state)
            S_IDLE:     accept = (DEBOUNCE_SCANS == 1);
            S_DEBOUNCE: accept = (key_idx == cand) && ((cnt + CNT_ONE) == CNT_TARGET);
            default:    accept = 1'b0;
         endcase
      end
      accept_info = decode_key(key_idx);
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state    <= S_IDLE;
         cand     <= 4'd0;
         cnt      <= '0;
         CODE     <= 4'd0;
         PRESS    <= 1'b0;
         ENTER    <= 1'b0;
         CLEAR    <= 1'b0;
         KEY_DOWN <= 1'b0;
      end else begin
         PRESS <= 1'b0;
         ENTER <= 1'b0;
         CLEAR <= 1'b0;
         if (accept) begin
            state    <= S_HELD;
            cnt      <= '0;
            KEY_DOWN <= 1'b1;
            case (accept_info.kind)
               K_DIGIT: begin
                  PRESS <= 1'b1;
                  CODE  <= accept_info.bcd;
               end
               K_ENTER: ENTER <= 1'b1;
               K_CLEAR: CLEAR <= 1'b1;
               default: ;
            endcase
         end else if (scan_end) begin
            case (state)
               S_IDLE: begin
                  if (scan_single) begin
                     cand  <= key_idx;
                     cnt   <= CNT_ONE;
                     state <= S_DEBOUNCE;
                  end
               end
               S_DEBOUNCE: begin
                  if (scan_single && (key_idx == cand)) begin
                     cnt <= cnt + CNT_ONE;
                  end else begin
                     cnt   <= '0;
                     state <= S_IDLE;
                  end
               end
               S_HELD: begin
                  if (!scan_none) begin
                     cnt <= '0;
                  end else if ((cnt + CNT_ONE) == CNT_TARGET) begin
                     cnt      <= '0;
                     state    <= S_IDLE;
                     KEY_DOWN <= 1'b0;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               default: begin
                  cnt   <= '0;
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan_encoder.sv
`timescale 1ns/1ps
// Scoreboard bench for keypad_scan_encoder: a keypad model drives ROW from
// COL, expected pulses are queued with the stimulus and popped on each pulse.
module tb_keypad_scan_encoder;

   localparam int SD       = 4;
   localparam int DS       = 3;
   localparam int SCAN_CYC = 4 * SD;

   localparam int EV_PRESS = 0;
   localparam int EV_ENTER = 1;
   localparam int EV_CLEAR = 2;

   localparam logic [15:0] KEY_1 = 16'h0001 << 0;
   localparam logic [15:0] KEY_2 = 16'h0001 << 1;
   localparam logic [15:0] KEY_A = 16'h0001 << 3;
   localparam logic [15:0] KEY_5 = 16'h0001 << 5;
   localparam logic [15:0] KEY_8 = 16'h0001 << 9;
   localparam logic [15:0] KEY_9 = 16'h0001 << 10;
   localparam logic [15:0] KEY_S = 16'h0001 << 12;
   localparam logic [15:0] KEY_0 = 16'h0001 << 13;
   localparam logic [15:0] KEY_H = 16'h0001 << 14;

   typedef struct {
      int         kind;
      logic [3:0] code;
   } ev_t;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic [3:0]  ROW;
   logic [3:0]  COL;
   logic [3:0]  CODE;
   logic        PRESS, ENTER, CLEAR, KEY_DOWN;
   logic [15:0] keys = '0;

   ev_t sb[$];
   int  total = 0;
   int  bad = 0;

   keypad_scan_encoder #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
      .CLK(CLK), .RESET(RESET), .ROW(ROW), .COL(COL), .CODE(CODE),
      .PRESS(PRESS), .ENTER(ENTER), .CLEAR(CLEAR), .KEY_DOWN(KEY_DOWN)
   );

   always #5 CLK = ~CLK;

   // A pressed key shorts its row to its column; driven column is low.
   always_comb begin
      ROW = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         ROW[r] = ~|(keys[4*r +: 4] & ~COL);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (RESET && (PRESS || ENTER || CLEAR)) begin
         check("pulse_onehot", 32'(PRESS) + 32'(ENTER) + 32'(CLEAR), 32'd1);
         if (sb.size() == 0) begin
            check("unexpected_pulse", 32'({PRESS, ENTER, CLEAR}), 32'd0);
         end else begin
            ev_t e;
            e = sb.pop_front();
            check("pulse_kind", PRESS ? EV_PRESS : (ENTER ? EV_ENTER : EV_CLEAR), 32'(e.kind));
            check("pulse_code", 32'(CODE), 32'(e.code));
            check("key_down_with_pulse", 32'(KEY_DOWN), 32'd1);
         end
      end
   end

   task automatic expect_ev(input int kind, input logic [3:0] code);
      ev_t e;
      #1;
      e.kind = kind;
      e.code = code;
      sb.push_back(e);
   endtask

   task automatic run_scans(input logic [15:0] pattern, input int n);
      repeat (n) begin
         keys = pattern;
         repeat (SCAN_CYC) @(negedge CLK);
      end
   endtask

   // Return on the first negedge after a scan wraps back to column 0.
   task automatic align();
      int n;
      n = 0;
      while (COL != 4'b0111 && n < 10 * SCAN_CYC) begin
         @(negedge CLK);
         n++;
      end
      while (COL != 4'b1110 && n < 10 * SCAN_CYC) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 10 * SCAN_CYC) check("align_timeout", n, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_col"},   32'(COL), 32'hE);
      check({tag, "_code"},  32'(CODE), 32'd0);
      check({tag, "_pulse"}, 32'({PRESS, ENTER, CLEAR}), 32'd0);
      check({tag, "_kd"},    32'(KEY_DOWN), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      keys  = '0;
      RESET = 1'b0;
      repeat (3) @(negedge CLK);
      check_reset_outputs("reset");
      RESET = 1'b1;
      align();

      // '5' held for 5 scans: one PRESS, KEY_DOWN until 3 empty scans.
      expect_ev(EV_PRESS, 4'd5);
      run_scans(KEY_5, 5);
      check("s1_kd_held", 32'(KEY_DOWN), 32'd1);
      run_scans('0, 2);
      check("s1_kd_two_empty", 32'(KEY_DOWN), 32'd1);
      run_scans('0, 1);
      check("s1_kd_released", 32'(KEY_DOWN), 32'd0);
      check("s1_drained", sb.size(), 32'd0);

      // '#' then '*': ENTER then CLEAR, CODE unchanged.
      expect_ev(EV_ENTER, 4'd5);
      run_scans(KEY_H, 3);
      run_scans('0, 3);
      expect_ev(EV_CLEAR, 4'd5);
      run_scans(KEY_S, 3);
      run_scans('0, 3);
      check("s2_code_kept", 32'(CODE), 32'd5);

      // '8' with a one-scan gap restarts debounce, then a clean press.
      run_scans(KEY_8, 2);
      run_scans('0, 1);
      run_scans(KEY_8, 2);
      run_scans('0, 1);
      check("s3_no_pulse_code", 32'(CODE), 32'd5);
      expect_ev(EV_PRESS, 4'd8);
      run_scans(KEY_8, 3);
      run_scans('0, 3);

      // Two keys together never accept; adding a key while held is ignored.
      run_scans(KEY_1 | KEY_2, 3);
      check("s4_multi_code", 32'(CODE), 32'd8);
      expect_ev(EV_PRESS, 4'd1);
      run_scans(KEY_1, 3);
      run_scans(KEY_1 | KEY_2, 3);
      check("s4_kd_multi_held", 32'(KEY_DOWN), 32'd1);
      check("s4_code_held", 32'(CODE), 32'd1);
      run_scans('0, 3);
      check("s4_kd_released", 32'(KEY_DOWN), 32'd0);

      // Reset in the middle of debouncing '9', away from column 0.
      run_scans(KEY_9, 2);
      repeat (SD + 1) @(negedge CLK);
      check("s6_col_before_reset", 32'(COL), 32'hD);
      RESET = 1'b0;
      #1;
      check_reset_outputs("s6_reset");
      repeat (3) @(negedge CLK);
      RESET = 1'b1;
      align();
      run_scans(KEY_9, 1);
      check("s6_no_early_code", 32'(CODE), 32'd0);
      expect_ev(EV_PRESS, 4'd9);
      run_scans(KEY_9, 1);
      check("s6_kd_after", 32'(KEY_DOWN), 32'd1);
      run_scans('0, 3);

      // Ignored key 'A' debounces and holds but emits nothing.
      run_scans(KEY_A, 5);
      check("s5_kd_ignored", 32'(KEY_DOWN), 32'd1);
      check("s5_code_ignored", 32'(CODE), 32'd9);
      run_scans('0, 3);
      check("s5_kd_released", 32'(KEY_DOWN), 32'd0);
      expect_ev(EV_PRESS, 4'd0);
      run_scans(KEY_0, 3);
      run_scans('0, 3);

      check("final_drained", sb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
